// File: rtl/sram_bank_ctrl.sv
// Row SRAM bank: one write port, two registered read ports, write-first bypass
// and a hardware clear sequencer that sweeps CLEAR_VAL over every row.
module sram_bank_ctrl #(
  parameter int unsigned       DATA_W    = 256,
  parameter int unsigned       ADDR_W    = 11,
  parameter int unsigned       DEPTH     = 2048,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_valid1,
  output logic              rd_err1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid2,
  output logic              rd_err2,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [7:0]        err_cnt
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e state_q;
  idx_t   cnt_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_range, wr_accept, wr_reject;
  logic              rd_in_range1, rd_in_range2;
  logic              rd_err_d1, rd_err_d2;
  logic              mem_we;
  idx_t              mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data_d1, rd_data_d2;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;
  logic [7:0]        err_cnt_d;

  always_comb begin
    wr_in_range  = 32'(wr_addr) < DEPTH;
    wr_accept    = wr_en && (state_q == StIdle) && wr_in_range;
    wr_reject    = wr_en && !wr_accept;
    rd_in_range1 = 32'(rd_addr1) < DEPTH;
    rd_in_range2 = 32'(rd_addr2) < DEPTH;
    rd_err_d1    = rd_en1 && !rd_in_range1;
    rd_err_d2    = rd_en2 && !rd_in_range2;

    // Clear and user writes never coincide: user writes are only taken in StIdle.
    mem_we    = wr_accept || (state_q == StClear);
    mem_waddr = (state_q == StClear) ? cnt_q : idx_t'(wr_addr);
    mem_wdata = (state_q == StClear) ? CLEAR_VAL : wr_data;
  end

  // Write-first: a write landing on the row being read this cycle wins over the array.
  always_comb begin
    rd_data_d1 = '0;
    if (rd_in_range1) begin
      if (mem_we && (mem_waddr == idx_t'(rd_addr1))) rd_data_d1 = mem_wdata;
      else                                             rd_data_d1 = mem[idx_t'(rd_addr1)];
    end
  end

  always_comb begin
    rd_data_d2 = '0;
    if (rd_in_range2) begin
      if (mem_we && (mem_waddr == idx_t'(rd_addr2))) rd_data_d2 = mem_wdata;
      else                                             rd_data_d2 = mem[idx_t'(rd_addr2)];
    end
  end

  always_comb begin
    err_inc   = {1'b0, wr_reject} + {1'b0, rd_err_d1} + {1'b0, rd_err_d2};
    err_sum   = {1'b0, err_cnt} + {7'd0, err_inc};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // Array contents survive reset, so the storage has no reset branch.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      rd_data1  <= '0;
      rd_valid1 <= 1'b0;
      rd_err1   <= 1'b0;
      rd_data2  <= '0;
      rd_valid2 <= 1'b0;
      rd_err2   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      clr_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_q  <= StClear;
            cnt_q    <= '0;
            clr_busy <= 1'b1;
          end
        end
        StClear: begin
          if (cnt_q == idx_t'(DEPTH - 1)) begin
            state_q  <= StDone;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt_q <= cnt_q + idx_t'(1);
          end
        end
        StDone: state_q <= StIdle;
        default: begin
          state_q  <= StIdle;
          clr_busy <= 1'b0;
        end
      endcase

      wr_ack    <= wr_accept;
      wr_err    <= wr_reject;
      rd_valid1 <= rd_en1;
      rd_err1   <= rd_err_d1;
      rd_valid2 <= rd_en2;
      rd_err2   <= rd_err_d2;
      if (rd_en1) rd_data1 <= rd_data_d1;
      if (rd_en2) rd_data2 <= rd_data_d2;
      err_cnt   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl at DEPTH=16, DATA_W=8, ADDR_W=5.
module tb_sram_bank_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned DP = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, wr_err;
  logic          rd_en1 = 1'b0, rd_en2 = 1'b0;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2, rd_err1, rd_err2;
  logic          clr_start = 1'b0;
  logic          clr_busy, clr_done;
  logic [7:0]    err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  sram_bank_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .wr_err   (wr_err),
    .rd_en1   (rd_en1),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_valid1(rd_valid1),
    .rd_err1  (rd_err1),
    .rd_en2   (rd_en2),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd_data2),
    .rd_valid2(rd_valid2),
    .rd_err2  (rd_err2),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .err_cnt  (err_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_row(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read1(input logic [AW-1:0] a);
    rd_en1 = 1'b1; rd_addr1 = a;
    tick();
    rd_en1 = 1'b0;
  endtask

  int busy_cycles;
  int done_seen;

  initial begin
    tick();
    tick();
    check("rst_wr_ack", 32'(wr_ack), 0);
    check("rst_rd_valid1", 32'(rd_valid1), 0);
    check("rst_rd_data1", 32'(rd_data1), 0);
    check("rst_rd_data2", 32'(rd_data2), 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    reset = 1'b1;
    tick();

    // Write then read.
    write_row(5'd3, 8'hA5);
    check("wr_ack", 32'(wr_ack), 1);
    check("wr_err_none", 32'(wr_err), 0);
    tick();
    read1(5'd3);
    check("rd_valid1", 32'(rd_valid1), 1);
    check("rd_data1_row3", 32'(rd_data1), 32'hA5);
    check("rd_err1_none", 32'(rd_err1), 0);
    tick();
    check("rd_valid1_pulse", 32'(rd_valid1), 0);
    check("rd_data1_hold", 32'(rd_data1), 32'hA5);

    // Bypass on both ports.
    write_row(5'd5, 8'h11);
    write_row(5'd4, 8'h44);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h22;
    rd_en1 = 1'b1; rd_addr1 = 5'd5;
    rd_en2 = 1'b1; rd_addr2 = 5'd5;
    tick();
    wr_en = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;
    check("byp_rd_data1", 32'(rd_data1), 32'h22);
    check("byp_rd_data2", 32'(rd_data2), 32'h22);
    read1(5'd5);
    check("byp_later", 32'(rd_data1), 32'h22);

    // Out of range write and read.
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 8'hFF;
    rd_en2 = 1'b1; rd_addr2 = 5'd17;
    tick();
    wr_en = 1'b0; rd_en2 = 1'b0;
    check("oor_wr_err", 32'(wr_err), 1);
    check("oor_wr_ack", 32'(wr_ack), 0);
    check("oor_rd_valid2", 32'(rd_valid2), 1);
    check("oor_rd_err2", 32'(rd_err2), 1);
    check("oor_rd_data2", 32'(rd_data2), 0);
    check("oor_err_cnt", 32'(err_cnt), 2);
    read1(5'd4);
    check("oor_row4_kept", 32'(rd_data1), 32'h44);

    // Full clear.
    for (int i = 0; i < 16; i++) write_row(AW'(i), DW'(8'h30 + i));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cycles = 0;
    done_seen = 0;
    for (int c = 0; c < 40 && done_seen == 0; c++) begin
      if (clr_busy) busy_cycles++;
      if (clr_done) begin
        done_seen = 1;
        check("clr_done_busy_low", 32'(clr_busy), 0);
      end
      wr_en = (c == 4); wr_addr = 5'd2; wr_data = 8'hEE;
      rd_en2 = (c == 4); rd_addr2 = 5'd12;
      clr_start = (c == 6);
      tick();
      if (c == 4) begin
        check("clr_wr_err", 32'(wr_err), 1);
        check("clr_rd_uncleared", 32'(rd_data2), 32'h3C);
      end
    end
    wr_en = 1'b0; rd_en2 = 1'b0; clr_start = 1'b0;
    check("clr_busy_cycles", 32'(busy_cycles), 16);
    check("clr_done_seen", 32'(done_seen), 1);
    check("clr_done_pulse", 32'(clr_done), 0);
    check("clr_err_cnt", 32'(err_cnt), 3);
    for (int i = 0; i < 16; i++) begin
      rd_en1 = 1'b1; rd_addr1 = AW'(i);
      rd_en2 = 1'b1; rd_addr2 = AW'(15 - i);
      tick();
      check($sformatf("clr_row_p1_%0d", i), 32'(rd_data1), 0);
      check($sformatf("clr_row_p2_%0d", 15 - i), 32'(rd_data2), 0);
      check($sformatf("clr_b2b_valid_%0d", i), 32'(rd_valid1), 1);
    end
    rd_en1 = 1'b0; rd_en2 = 1'b0;

    // Reset mid-clear.
    for (int i = 0; i < 16; i++) write_row(AW'(i), DW'(8'h50 + i));
    read1(5'd15);
    check("mid_pre_rd", 32'(rd_data1), 32'h5F);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (6) tick();
    check("mid_busy", 32'(clr_busy), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(clr_busy), 0);
    check("mid_rst_done", 32'(clr_done), 0);
    check("mid_rst_err_cnt", 32'(err_cnt), 0);
    check("mid_rst_rd_data1", 32'(rd_data1), 0);
    check("mid_rst_rd_valid1", 32'(rd_valid1), 0);
    check("mid_rst_wr_ack", 32'(wr_ack), 0);
    tick();
    tick();
    reset = 1'b1;
    done_seen = 0;
    busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (clr_done) done_seen++;
      if (clr_busy) busy_cycles++;
    end
    check("mid_no_done", 32'(done_seen), 0);
    check("mid_no_busy", 32'(busy_cycles), 0);
    for (int i = 0; i < 6; i++) begin
      read1(AW'(i));
      check($sformatf("mid_row_%0d", i), 32'(rd_data1), 0);
    end
    read1(5'd6);
    check("mid_row_6", 32'(rd_data1), 32'h56);
    read1(5'd10);
    check("mid_row_10", 32'(rd_data1), 32'h5A);

    // err_cnt saturation.
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 8'h01;
    rd_en1 = 1'b1; rd_addr1 = 5'd17;
    rd_en2 = 1'b1; rd_addr2 = 5'd31;
    tick();
    check("sat_first", 32'(err_cnt), 3);
    check("sat_rd_err1", 32'(rd_err1), 1);
    repeat (99) tick();
    check("sat_255", 32'(err_cnt), 255);
    wr_en = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;
    tick();
    check("sat_hold", 32'(err_cnt), 255);
    read1(5'd4);
    check("sat_row4_kept", 32'(rd_data1), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_bank_ctrl.md
# sram_bank_ctrl

Parametrised successor to the fixed-size row SRAMs used for the I and Y matrices. It provides one write port, two independent registered read ports, write-first bypass and a hardware clear sequencer. The block sits between the compute top and the memory array, and is configured per instance (e.g. 240b×256 rows for I, 256b×2048 rows for Y). Row data is opaque to the block.

## Interface
- DATA_W, 256, row width in bits
- ADDR_W, 11, address width
- DEPTH, 2048, number of rows; legal range is 2..2^ADDR_W
- CLEAR_VAL, {DATA_W{1'b0}}, row value written by the clear sequencer

Ports:
- clock  in  1  single clock; everything is on the rising edge
- reset  in  1  asynchronous, active-low; asserting it clears all control state and outputs; array contents are not cleared
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write row
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse: write committed
- wr_err  out  1  one-cycle pulse: write rejected
- rd_en1, rd_en2  in  1  read requests, ports 1 and 2
- rd_addr1, rd_addr2  in  ADDR_W  read rows
- rd_data1, rd_data2  out  DATA_W  registered read data; holds its value until the next read on that port
- rd_valid1, rd_valid2  out  1  one-cycle pulse: rd_data updated
- rd_err1, rd_err2  out  1  pulse with rd_valid when the address is ≥ DEPTH
- clr_start  in  1  start clear sequence
- clr_busy  out  1  high while the clear is in progress
- clr_done  out  1  one-cycle pulse at the end of the clear
- err_cnt  out  8  saturating count of wr_err plus rd_err events

## Operation
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE→CLEAR on clr_start. The row counter loads 0.
  - CLEAR writes CLEAR_VAL to the counter row, then increments the counter. It goes to DONE after row DEPTH-1.
  - DONE lasts one cycle, pulses clr_done, then returns to IDLE.
  - clr_start is ignored outside IDLE.
- Write rules:
  - wr_en in IDLE with wr_addr < DEPTH commits the row and gives wr_ack.
  - wr_addr ≥ DEPTH gives wr_err and no array change.
  - wr_en while clr_busy=1 or in DONE gives wr_err and is dropped.
- Read rules:
  - Reads are always served, including during a clear; cleared rows return CLEAR_VAL and uncleared rows return their old value.
  - An address ≥ DEPTH returns all-zero data with rd_valid=1 and rd_err=1.
- Bypass (write-first):
  - A same-cycle accepted write to the same row as rd_addrN makes rd_dataN return wr_data.
  - A same-cycle clear write to the row being read returns CLEAR_VAL.
  - Both ports may read the same row; both get identical data.
- err_cnt adds the number of error pulses in the cycle (0–3) and saturates at 255. Only reset clears it.

## Timing
- Reset values: every output is 0, rd_data is all zeros, and the FSM is in IDLE.
- Read latency is 1 cycle: rd_en at edge N gives rd_valid and data at edge N+1. Back-to-back reads run every cycle.
- Write latency: wr_ack/wr_err appear one cycle after wr_en, and the row is readable (without bypass) from the next cycle on.
- Clear timing:
  - clr_start sampled at edge N gives clr_busy=1 from N+1 for DEPTH cycles.
  - clr_done pulses at N+DEPTH+1, with clr_busy already 0.
  - The total IDLE-to-IDLE time is DEPTH+2 cycles.
- Reset asserted mid-clear aborts at once: IDLE, clr_busy=0, no clr_done. Rows cleared so far stay cleared.
- A new clr_start is accepted the cycle after DONE.

## Test plan
- Reset then write/read:
  - Stimulus: DEPTH=16, DATA_W=8. Write 0xA5 to row 3; two cycles later read row 3 on port 1.
  - Required: wr_ack one cycle after wr_en; rd_data1=0xA5 with rd_valid1 pulse one cycle after rd_en.
- Bypass:
  - Stimulus: row 5 holds 0x11. Write 0x22 to row 5 and read row 5 on both ports in the same cycle.
  - Required: rd_data1=rd_data2=0x22 next cycle; a later read returns 0x22.
- Out of range:
  - Stimulus: write row 20 and read row 17 on port 2 in the same cycle.
  - Required: wr_err=1, rd_valid2=rd_err2=1 with rd_data2=0, err_cnt=2; no array row changes.
- Full clear:
  - Stimulus: fill rows with nonzero data, then pulse clr_start.
  - Required: clr_busy high for exactly 16 cycles; clr_done one cycle later; all rows read 0.
  - Also: a wr_en issued during busy gives wr_err and row unchanged; a second clr_start during busy is ignored.
- Reset mid-clear:
  - Stimulus: assert reset 6 cycles into a clear.
  - Required: rows 0–5 read 0 and row 10 keeps its old value; all outputs 0; no clr_done.
- err_cnt saturation:
  - Stimulus: 100 cycles of out-of-range write plus two out-of-range reads.
  - Required: err_cnt holds at 255.
